// File: rtl/pipeline_control_unit_pkg.sv
// Shared types for the LC-3b pipeline stall/flush sequencer.
//   lc3b_reg            : 3-bit register specifier
//   lc3b_pipe_ctl_state : sequencer FSM states
//   pipe_ctl_t          : bundle of per-stage load/flush controls
package pipeline_control_unit_pkg;

  typedef logic [2:0] lc3b_reg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LU_BUBBLE = 2'd1,
    DWAIT     = 2'd2
  } lc3b_pipe_ctl_state;

  typedef struct packed {
    logic load_pc;
    logic load_if_de;
    logic load_de_ex;
    logic load_ex_mem;
    logic load_mem_wb;
    logic flush_if_de;
    logic flush_de_ex;
    logic flush_ex_mem;
    logic flush_mem_wb;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_IDLE     = 9'b00000_0000;
  localparam pipe_ctl_t CTL_NORMAL   = 9'b11111_0000;
  // Upper stages and PC hold; the MEM instruction is retired as a NOP into WB.
  localparam pipe_ctl_t CTL_FREEZE   = 9'b00001_0001;
  localparam pipe_ctl_t CTL_REDIRECT = 9'b11111_1110;
  localparam pipe_ctl_t CTL_LOAD_USE = 9'b00111_0100;
  localparam pipe_ctl_t CTL_IMISS    = 9'b01111_1000;

  // Source operand depends on the EX destination. R0 is a real register,
  // so no special case for register 0.
  function automatic logic reg_dep(lc3b_reg dr, lc3b_reg src, logic uses);
    return uses && (dr == src);
  endfunction

endpackage

// File: rtl/pipeline_control_unit_if.sv
// Handshake/control bundle between the pipeline sequencer (master) and the
// datapath / caches (slave).
//   inputs to master : cache responses, hazard operands, branch resolution
//   outputs of master: fetch request, stage load/flush enables, perf counters
interface pipeline_control_unit_if #(
  parameter int CNT_WIDTH = 16
);
  import pipeline_control_unit_pkg::*;

  logic                 i_mem_resp;
  logic                 d_mem_req;
  logic                 d_mem_resp;
  logic                 de_ex_mem_read;
  lc3b_reg              de_ex_dr;
  lc3b_reg              if_de_rs;
  lc3b_reg              if_de_rt;
  logic                 if_de_uses_rs;
  logic                 if_de_uses_rt;
  logic                 branch_taken;

  logic                 i_mem_read;
  logic                 load_pc;
  logic                 load_if_de;
  logic                 load_de_ex;
  logic                 load_ex_mem;
  logic                 load_mem_wb;
  logic                 flush_if_de;
  logic                 flush_de_ex;
  logic                 flush_ex_mem;
  logic                 flush_mem_wb;
  logic [CNT_WIDTH-1:0] stall_cycles;
  logic [CNT_WIDTH-1:0] flush_count;

  modport master (
    input  i_mem_resp, d_mem_req, d_mem_resp, de_ex_mem_read, de_ex_dr,
           if_de_rs, if_de_rt, if_de_uses_rs, if_de_uses_rt, branch_taken,
    output i_mem_read, load_pc, load_if_de, load_de_ex, load_ex_mem,
           load_mem_wb, flush_if_de, flush_de_ex, flush_ex_mem, flush_mem_wb,
           stall_cycles, flush_count
  );

  modport slave (
    output i_mem_resp, d_mem_req, d_mem_resp, de_ex_mem_read, de_ex_dr,
           if_de_rs, if_de_rt, if_de_uses_rs, if_de_uses_rt, branch_taken,
    input  i_mem_read, load_pc, load_if_de, load_de_ex, load_ex_mem,
           load_mem_wb, flush_if_de, flush_de_ex, flush_ex_mem, flush_mem_wb,
           stall_cycles, flush_count
  );

endinterface

// File: rtl/pipeline_control_unit_sat_counter.sv
// Saturating up-counter: increments on inc, holds at all-ones.
//   clk, reset (async, active-high), inc -> count[WIDTH-1:0]
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_control_unit.sv
// Stall/flush sequencer for the 5-stage LC-3b pipeline.
//   clk, reset (async, active-high)
//   bus (master): cache handshakes, load-use operands, branch resolution in;
//                 fetch request, stage load/flush enables, stall/flush counters out
// Stage controls are combinational so a cache response advances the pipe in
// the same cycle it arrives; only the sequencing state is registered.
//
// state     | meaning
// RUN       | normal operation, load-use hazards evaluated
// LU_BUBBLE | one load-use bubble just inserted, hazard not re-checked
// DWAIT     | D-cache access outstanding, pipe frozen
module pipeline_control_unit
  import pipeline_control_unit_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  pipeline_control_unit_if.master  bus
);

  lc3b_pipe_ctl_state state_q;
  lc3b_pipe_ctl_state state_d;
  pipe_ctl_t          ctl;
  logic               redirect;
  logic               d_miss;
  logic               lu_hazard;

  assign d_miss    = bus.d_mem_req && !bus.d_mem_resp;
  assign lu_hazard = bus.de_ex_mem_read &&
                     (reg_dep(bus.de_ex_dr, bus.if_de_rs, bus.if_de_uses_rs) ||
                      reg_dep(bus.de_ex_dr, bus.if_de_rt, bus.if_de_uses_rt));

  always_comb begin
    ctl      = CTL_IDLE;
    state_d  = RUN;
    redirect = 1'b0;
    if (reset) begin
      ctl = CTL_IDLE;
    end else if (d_miss) begin
      ctl     = CTL_FREEZE;
      state_d = DWAIT;
    end else if (bus.branch_taken && !bus.i_mem_resp) begin
      // Keep PC stable until the outstanding fetch completes.
      ctl = CTL_FREEZE;
    end else if (bus.branch_taken) begin
      ctl      = CTL_REDIRECT;
      redirect = 1'b1;
    end else if ((state_q == RUN) && lu_hazard) begin
      ctl     = CTL_LOAD_USE;
      state_d = LU_BUBBLE;
    end else if (!bus.i_mem_resp) begin
      ctl = CTL_IMISS;
    end else begin
      ctl = CTL_NORMAL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.i_mem_read   = !reset;
  assign bus.load_pc      = ctl.load_pc;
  assign bus.load_if_de   = ctl.load_if_de;
  assign bus.load_de_ex   = ctl.load_de_ex;
  assign bus.load_ex_mem  = ctl.load_ex_mem;
  assign bus.load_mem_wb  = ctl.load_mem_wb;
  assign bus.flush_if_de  = ctl.flush_if_de;
  assign bus.flush_de_ex  = ctl.flush_de_ex;
  assign bus.flush_ex_mem = ctl.flush_ex_mem;
  assign bus.flush_mem_wb = ctl.flush_mem_wb;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!ctl.load_pc && !reset),
    .count (bus.stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (redirect),
    .count (bus.flush_count)
  );

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed bench for pipeline_control_unit. Counter width is reduced so
// saturation is reachable in a few cycles.
module tb_pipeline_control_unit;
  import pipeline_control_unit_pkg::*;

  localparam int W = 4;

  // {load_pc, load_if_de, load_de_ex, load_ex_mem, load_mem_wb,
  //  flush_if_de, flush_de_ex, flush_ex_mem, flush_mem_wb}
  localparam logic [8:0] V_IDLE   = 9'b00000_0000;
  localparam logic [8:0] V_NORMAL = 9'b11111_0000;
  localparam logic [8:0] V_FREEZE = 9'b00001_0001;
  localparam logic [8:0] V_REDIR  = 9'b11111_1110;
  localparam logic [8:0] V_LU     = 9'b00111_0100;
  localparam logic [8:0] V_IMISS  = 9'b01111_1000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  pipeline_control_unit_if #(.CNT_WIDTH(W)) bus ();

  pipeline_control_unit #(.CNT_WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [8:0] ctl_v;
  assign ctl_v = {bus.load_pc, bus.load_if_de, bus.load_de_ex, bus.load_ex_mem,
                  bus.load_mem_wb, bus.flush_if_de, bus.flush_de_ex,
                  bus.flush_ex_mem, bus.flush_mem_wb};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_mem_resp     = 1'b1;
    bus.d_mem_req      = 1'b0;
    bus.d_mem_resp     = 1'b0;
    bus.de_ex_mem_read = 1'b0;
    bus.de_ex_dr       = 3'd0;
    bus.if_de_rs       = 3'd0;
    bus.if_de_rt       = 3'd0;
    bus.if_de_uses_rs  = 1'b0;
    bus.if_de_uses_rt  = 1'b0;
    bus.branch_taken   = 1'b0;
  endtask

  task automatic set_lu(input lc3b_reg dr, input lc3b_reg rs, input lc3b_reg rt,
                        input logic urs, input logic urt);
    bus.de_ex_mem_read = 1'b1;
    bus.de_ex_dr       = dr;
    bus.if_de_rs       = rs;
    bus.if_de_rt       = rt;
    bus.if_de_uses_rs  = urs;
    bus.if_de_uses_rt  = urt;
  endtask

  // Inputs already applied just after a negedge: check controls, cross posedge.
  task automatic cyc(input string tag, input logic [8:0] exp);
    #1;
    check(tag, 32'(ctl_v), 32'(exp));
    @(negedge clk);
  endtask

  task automatic cnts(input string tag, input int stall, input int flush);
    check({tag, "_stall"}, 32'(bus.stall_cycles), 32'(stall));
    check({tag, "_flush"}, 32'(bus.flush_count), 32'(flush));
  endtask

  initial begin
    idle_inputs();
    #1;
    check("rst_ctl", 32'(ctl_v), 32'(V_IDLE));
    check("rst_imem_read", 32'(bus.i_mem_read), 32'd0);
    cnts("rst", 0, 0);
    @(negedge clk);
    reset = 1'b0;

    #1;
    check("run_imem_read", 32'(bus.i_mem_read), 32'd1);
    cyc("normal", V_NORMAL);
    cnts("normal", 0, 0);

    // Load-use on rs=R3: single bubble, none while inputs held in LU_BUBBLE
    set_lu(3'd3, 3'd3, 3'd1, 1'b1, 1'b1);
    cyc("lu_bubble", V_LU);
    cyc("lu_no_second", V_NORMAL);
    idle_inputs();
    cnts("lu", 1, 0);

    // D-miss for 4 cycles then response
    bus.d_mem_req = 1'b1;
    for (int i = 0; i < 4; i++) cyc("dmiss", V_FREEZE);
    bus.d_mem_resp = 1'b1;
    cyc("dmiss_resp", V_NORMAL);
    idle_inputs();
    cnts("dmiss", 5, 0);

    // Taken branch with fetch complete
    bus.branch_taken = 1'b1;
    cyc("redirect", V_REDIR);
    cnts("redirect", 5, 1);

    // Taken branch with fetch outstanding for 3 cycles
    bus.i_mem_resp = 1'b0;
    for (int i = 0; i < 3; i++) cyc("br_wait", V_FREEZE);
    bus.i_mem_resp = 1'b1;
    cyc("br_fire", V_REDIR);
    idle_inputs();
    cnts("br_wait", 8, 2);

    // I-miss
    bus.i_mem_resp = 1'b0;
    cyc("imiss", V_IMISS);
    idle_inputs();
    cnts("imiss", 9, 2);

    // R0 match on rt stalls; unused source never stalls
    set_lu(3'd0, 3'd5, 3'd0, 1'b0, 1'b1);
    cyc("lu_r0", V_LU);
    idle_inputs();
    cyc("after_r0", V_NORMAL);
    set_lu(3'd2, 3'd2, 3'd2, 1'b0, 1'b0);
    cyc("lu_unused", V_NORMAL);
    idle_inputs();
    cnts("r0", 10, 2);

    // Load-use together with D-miss: freeze wins, hazard seen only back in RUN
    set_lu(3'd4, 3'd4, 3'd0, 1'b1, 1'b0);
    bus.d_mem_req = 1'b1;
    for (int i = 0; i < 2; i++) cyc("lu_dmiss", V_FREEZE);
    bus.d_mem_resp = 1'b1;
    cyc("lu_dmiss_resp", V_NORMAL);
    bus.d_mem_req  = 1'b0;
    bus.d_mem_resp = 1'b0;
    cyc("lu_after_resp", V_LU);
    idle_inputs();
    cyc("lu_after_bubble", V_NORMAL);
    cnts("lu_dmiss", 13, 2);

    // Saturation of stall_cycles at all-ones
    bus.d_mem_req = 1'b1;
    for (int i = 0; i < 4; i++) cyc("sat_dmiss", V_FREEZE);
    idle_inputs();
    cnts("sat", 15, 2);
    bus.i_mem_resp = 1'b0;
    cyc("sat_imiss", V_IMISS);
    idle_inputs();
    cnts("sat_hold", 15, 2);

    // Reset asserted mid-DWAIT acts immediately
    bus.d_mem_req = 1'b1;
    #1;
    check("pre_rst_dmiss", 32'(ctl_v), 32'(V_FREEZE));
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_ctl", 32'(ctl_v), 32'(V_IDLE));
    check("async_rst_imem_read", 32'(bus.i_mem_read), 32'd0);
    cnts("async_rst", 0, 0);
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    set_lu(3'd6, 3'd1, 3'd6, 1'b1, 1'b1);
    cyc("post_rst_lu", V_LU);
    idle_inputs();
    cnts("post_rst", 1, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_control_unit.md
Name: pipeline_control_unit

Overview:
Central stall/flush sequencer for the 5-stage LC-3b pipeline (IF, DE, EX, MEM, WB). It combines the I-cache and D-cache handshakes, load-use hazards and taken-branch redirects into the per-stage register load enables, the bubble (flush) controls and the PC load. It covers only the hazards that operand forwarding cannot resolve, and keeps saturating stall and flush performance counters.

Parameters:
CNT_WIDTH, 16, width of the stall_cycles and flush_count performance counters

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high; clears state and counters
i_mem_resp  in  1  I-cache response; fetch at PC completes this cycle
d_mem_req  in  1  instruction in MEM stage issues a D-cache read or write
d_mem_resp  in  1  D-cache response for the MEM-stage access
de_ex_mem_read  in  1  instruction in EX is a load (LDB/LDR/LDI)
de_ex_dr  in  3  destination register of EX instruction (lc3b_reg)
if_de_rs  in  3  source register 1 of DE instruction
if_de_rt  in  3  source register 2 of DE instruction
if_de_uses_rs  in  1  DE instruction reads rs
if_de_uses_rt  in  1  DE instruction reads rt
branch_taken  in  1  MEM-stage control transfer resolved taken
i_mem_read  out  1  fetch request to I-cache
load_pc  out  1  PC register enable
load_if_de  out  1  IF/DE enable
load_de_ex  out  1  DE/EX enable
load_ex_mem  out  1  EX/MEM enable
load_mem_wb  out  1  MEM/WB enable
flush_if_de  out  1  load NOP into IF/DE (only meaningful with load_if_de=1)
flush_de_ex  out  1  load NOP into DE/EX
flush_ex_mem  out  1  load NOP into EX/MEM
flush_mem_wb  out  1  load NOP into MEM/WB
stall_cycles  out  CNT_WIDTH  count of cycles with load_pc=0, saturating
flush_count  out  CNT_WIDTH  count of taken-branch redirects, saturating

Behaviour:
- Interface fixed: single clock clk; reset is asynchronous, active-high, port name reset.
- FSM states: RUN, LU_BUBBLE, DWAIT. Reset -> RUN and both counters = 0.
- In every state, i_mem_read = 1 except during reset. With reset asserted all load_* = 0 and all flush_* = 0.
- Priority of conditions, evaluated every cycle: (1) D-miss, (2) I-fetch-pending-with-branch, (3) branch redirect, (4) load-use, (5) I-miss, (6) normal.
- D-miss (d_mem_req & !d_mem_resp):
  - load_pc, load_if_de, load_de_ex and load_ex_mem = 0.
  - load_mem_wb = 1 with flush_mem_wb = 1.
  - State goes to DWAIT and stays there while the miss persists.
  - In the cycle d_mem_resp = 1, normal advance happens and the state returns to RUN.
- Branch while fetch outstanding (branch_taken & !i_mem_resp): same freeze as a D-miss, so the PC stays stable for the I-cache. The redirect fires in the first cycle that i_mem_resp = 1.
- Branch redirect (branch_taken & i_mem_resp):
  - All load_* = 1.
  - flush_if_de, flush_de_ex and flush_ex_mem = 1; the fetched word is discarded.
  - The datapath muxes the target into PC; flush_count increments.
- Load-use (in RUN only): de_ex_mem_read & de_ex_dr matches a used source (if_de_rs with if_de_uses_rs, or if_de_rt with if_de_uses_rt).
  - load_pc = 0 and load_if_de = 0.
  - load_de_ex = 1 with flush_de_ex = 1; later stages advance.
  - State goes to LU_BUBBLE.
- LU_BUBBLE: exactly one bubble is inserted. Load-use is not re-evaluated; the state returns to RUN next cycle. The EX load now forwards from MEM/WB.
- R0 is a real register in LC-3b, so a match on register 0 stalls.
- I-miss (!i_mem_resp, none of the above):
  - load_pc = 0.
  - load_if_de = 1 with flush_if_de = 1.
  - Downstream stages advance.
- Normal: all load_* = 1, all flush_* = 0.
- stall_cycles increments by 1 on every cycle with load_pc = 0 and holds at all-ones.
- flush_count increments on each redirect cycle and holds at all-ones.
- Reset mid-DWAIT or mid-LU_BUBBLE returns to RUN immediately (asynchronous) and clears the counters.

Decomposition:
- lc3b_types gains the enum lc3b_pipe_ctl_state {RUN, LU_BUBBLE, DWAIT}; the existing lc3b_reg is used for register ports.
- One natural sub-module, sat_counter (parameterised width; inc and reset inputs), instantiated twice.
- Hazard compare and priority select stay in the top module.

Test Plan:
- Reset asserted mid-run -> all load_*/flush_* = 0 asynchronously; after release, state RUN and stall_cycles = 0, flush_count = 0.
- LDR R3 in EX, ADD using rs=R3 in DE -> one cycle with load_pc = 0, load_if_de = 0, flush_de_ex = 1, then normal. stall_cycles = 1; no second bubble even if inputs are held.
- d_mem_req = 1 with d_mem_resp low for 4 cycles -> 4 cycles of full freeze with flush_mem_wb = 1. On the resp cycle all load_* = 1; stall_cycles += 4.
- branch_taken with i_mem_resp = 1 -> flush_if_de, flush_de_ex and flush_ex_mem = 1 in the same cycle, all load_* = 1, flush_count = 1.
- branch_taken while i_mem_resp is low for 3 cycles -> PC and upper stages are frozen for 3 cycles; the redirect and flushes occur in the cycle i_mem_resp rises.
- Load-use and D-miss in the same cycle -> D-miss freeze wins; load-use is evaluated after resp. Separately, force stall_cycles to all-ones and stall once more -> the value holds.
